// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller: one LW/LB/SW per access, req/rdy memory handshake
// Stalls execute until the access completes; flags misaligned word accesses and memory timeouts.
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_is_lw,
  input  logic        i_is_lb,
  input  logic        i_is_sw,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [14:0] o_mem_ad,
  output logic [1:0]  o_mem_be,
  output logic [15:0] o_mem_wdata,
  input  logic        i_mem_rdy,
  input  logic [15:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_is_sw;
  logic             r_is_lb;
  logic             r_addr0;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_rdata;
  logic             r_err;
  logic             r_mem_we;
  logic [14:0]      r_mem_ad;
  logic [1:0]       r_mem_be;
  logic [15:0]      r_mem_wdata;

  logic w_accept;
  logic w_sel_sw;
  logic w_sel_lw;
  logic w_word;
  logic w_misalign;
  logic w_timeout;

  // Type priority SW > LW > LB; anything not SW/LW that was accepted is LB.
  assign w_accept   = (r_state == IDLE) && i_start && (i_is_lw || i_is_lb || i_is_sw);
  assign w_sel_sw   = i_is_sw;
  assign w_sel_lw   = !i_is_sw && i_is_lw;
  assign w_word     = w_sel_sw || w_sel_lw;
  assign w_misalign = w_word && i_addr[0];
  // Abort on the REQ cycle whose missed rdy would bring the wait count to TIMEOUT_CYC.
  assign w_timeout  = (r_state == REQ) && !i_mem_rdy && (r_cnt >= CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_misalign ? DONE : REQ;
        end
      end
      REQ: begin
        if (i_mem_rdy || w_timeout) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_stall   = w_accept || (r_state == REQ);
    o_done    = (r_state == DONE);
    o_mem_req = (r_state == REQ);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_sw     <= 1'b0;
      r_is_lb     <= 1'b0;
      r_addr0     <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= 16'h0000;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_ad    <= 15'h0000;
      r_mem_be    <= 2'b00;
      r_mem_wdata <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_err   <= w_misalign;
            r_cnt   <= '0;
            r_is_sw <= w_sel_sw;
            r_is_lb <= !w_word;
            r_addr0 <= i_addr[0];
            if (!w_misalign) begin
              r_mem_we    <= w_sel_sw;
              r_mem_ad    <= i_addr[15:1];
              r_mem_be    <= w_word ? 2'b11 : (i_addr[0] ? 2'b10 : 2'b01);
              r_mem_wdata <= i_wdata;
            end
          end
        end
        REQ: begin
          if (i_mem_rdy) begin
            if (r_is_lb) begin
              r_rdata <= {8'h00, (r_addr0 ? i_mem_rdata[15:8] : i_mem_rdata[7:0])};
            end else if (!r_is_sw) begin
              r_rdata <= i_mem_rdata;
            end
          end else begin
            if (r_cnt != {CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
              r_err   <= 1'b1;
              r_rdata <= 16'hFFFF;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rdata     = r_rdata;
  assign o_err       = r_err;
  assign o_mem_we    = r_mem_we;
  assign o_mem_ad    = r_mem_ad;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl against a byte-addressed memory model
`timescale 1ns/1ps
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_lw, is_lb, is_sw;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        stall, done, err;
  logic        mem_req, mem_we;
  logic [14:0] mem_ad;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_rdy;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_is_lw(is_lw), .i_is_lb(is_lb), .i_is_sw(is_sw),
    .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .o_stall(stall), .o_done(done), .o_err(err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_ad(mem_ad),
    .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_rdy(mem_rdy), .i_mem_rdata(mem_rdata)
  );

  typedef struct {
    int          start_cyc;
    int          lat;
    int          req_n;
    int          waits;
    bit          misal;
    bit          tmo;
    logic [15:0] rdata;
    logic        err;
    logic [14:0] ad;
    logic [1:0]  be;
    logic        we;
    logic [15:0] wdata;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  bmem [0:65535];
  logic [15:0] model_rdata;
  int          cyc = 0;
  int          req_cycles;
  bit          sb_en;
  int          total, bad;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] word_at(input logic [14:0] wa);
    return {bmem[{wa, 1'b1}], bmem[{wa, 1'b0}]};
  endfunction

  task automatic do_op(input logic f_sw, input logic f_lw, input logic f_lb,
                       input logic [15:0] a, input logic [15:0] wd,
                       input int waits, input bit tmo, input bit poke);
    exp_t e;
    bit   t_sw, t_lw, word;
    bit   poked;
    int   n;
    t_sw    = f_sw;
    t_lw    = !f_sw && f_lw;
    word    = t_sw || t_lw;
    e.misal = word && a[0];
    e.tmo   = tmo && !e.misal;
    e.waits = waits;
    e.ad    = a[15:1];
    e.be    = word ? 2'b11 : (a[0] ? 2'b10 : 2'b01);
    e.we    = t_sw;
    e.wdata = wd;
    if (e.misal)    e.rdata = model_rdata;
    else if (e.tmo) e.rdata = 16'hFFFF;
    else if (t_lw)  e.rdata = word_at(a[15:1]);
    else if (!t_sw) e.rdata = {8'h00, bmem[a]};
    else            e.rdata = model_rdata;
    model_rdata = e.rdata;
    e.err   = e.misal || e.tmo;
    e.lat   = e.misal ? 1 : (e.tmo ? 1 + TO : 2 + waits);
    e.req_n = e.misal ? 0 : (e.tmo ? TO : waits + 1);
    @(negedge clk);
    e.start_cyc = cyc;
    q.push_back(e);
    start = 1'b1; is_sw = f_sw; is_lw = f_lw; is_lb = f_lb; addr = a; wdata = wd;
    #1 chk("stall_on_accept", stall, 1'b1);
    @(negedge clk);
    start = 1'b0; is_sw = 1'b0; is_lw = 1'b0; is_lb = 1'b0;
    poked = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      if (poke && !poked && done) begin
        poked = 1'b1;
        start = 1'b1; is_sw = 1'b1; is_lw = 1'b1; is_lb = 1'b1; addr = 16'h0100;
        #1 chk("stall_in_done", stall, 1'b0);
        @(negedge clk);
        start = 1'b0; is_sw = 1'b0; is_lw = 1'b0; is_lb = 1'b0;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; is_lw = 1'b0; is_lb = 1'b0; is_sw = 1'b0;
    addr = 16'h0; wdata = 16'h0; mem_rdy = 1'b0; mem_rdata = 16'h0;
    total = 0; bad = 0; req_cycles = 0; sb_en = 1'b0; model_rdata = 16'h0;
    for (int i = 0; i < 65536; i++) bmem[i] = 8'($urandom);

    fork
      forever begin
        @(negedge clk);
        if (sb_en && done) begin
          if (q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("rdata", rdata, e.rdata);
            chk("err", err, e.err);
            chk("latency", cyc - e.start_cyc, e.lat);
            chk("req_cycles", req_cycles, e.req_n);
            chk("stall_at_done", stall, 1'b0);
          end
          req_cycles = 0;
        end
        if (sb_en && mem_req) begin
          if (q.size() == 0) begin
            chk("req_unexpected", 1, 0);
            mem_rdy = 1'b0;
          end else begin
            chk("mem_ad", mem_ad, q[0].ad);
            chk("mem_be", mem_be, q[0].be);
            chk("mem_we", mem_we, q[0].we);
            if (q[0].we) chk("mem_wdata", mem_wdata, q[0].wdata);
            chk("stall_in_req", stall, 1'b1);
            req_cycles++;
            if (!q[0].tmo && req_cycles > q[0].waits) begin
              mem_rdy   = 1'b1;
              mem_rdata = word_at(mem_ad);
              if (mem_we) begin
                if (mem_be[0]) bmem[{mem_ad, 1'b0}] = mem_wdata[7:0];
                if (mem_be[1]) bmem[{mem_ad, 1'b1}] = mem_wdata[15:8];
              end
            end else begin
              mem_rdy   = 1'b0;
              mem_rdata = 16'($urandom);
            end
          end
        end else begin
          mem_rdy   = 1'b0;
          mem_rdata = 16'($urandom);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_ad", mem_ad, 15'h0);
    chk("rst_be", mem_be, 2'b00);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_wdata", mem_wdata, 16'h0);
    chk("rst_stall", stall, 1'b0);
    sb_en = 1'b1;

    bmem[16'h0010] = 8'hEF; bmem[16'h0011] = 8'hBE;
    bmem[16'h0020] = 8'h5A; bmem[16'h0021] = 8'hA5;
    do_op(0, 1, 0, 16'h0010, 16'h0000, 0, 0, 0);
    do_op(0, 0, 1, 16'h0021, 16'h0000, 3, 0, 0);
    do_op(1, 0, 0, 16'h0004, 16'h1234, 1, 0, 0);
    do_op(0, 1, 0, 16'h0003, 16'h0000, 0, 0, 0);
    do_op(0, 1, 0, 16'h0010, 16'h0000, 2, 0, 1);
    do_op(0, 1, 0, 16'h0100, 16'h0000, 0, 1, 0);
    do_op(0, 0, 1, 16'h0010, 16'h0000, 0, 0, 0);
    do_op(1, 1, 1, 16'h0011, 16'h5555, 0, 0, 0);
    do_op(1, 1, 1, 16'h0030, 16'hC3A1, 0, 0, 0);
    do_op(0, 1, 1, 16'h0030, 16'h0000, 1, 0, 0);
    do_op(0, 0, 1, 16'h0031, 16'h0000, 0, 0, 1);

    // start with no type flag must be ignored
    @(negedge clk);
    start = 1'b1; addr = 16'h0040;
    #1 chk("stall_noflag", stall, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  fl;
      logic [15:0] a;
      fl = 3'($urandom_range(1, 7));
      a  = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      do_op(fl[2], fl[1], fl[0], a, 16'($urandom), int'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    // reset in the second REQ cycle abandons the access
    sb_en = 1'b0;
    @(negedge clk);
    start = 1'b1; is_lw = 1'b1; addr = 16'h0040;
    @(negedge clk);
    start = 1'b0; is_lw = 1'b0;
    @(negedge clk);
    chk("req_before_rst", mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_rdata", rdata, 16'h0);
    chk("rst_mid_err", err, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_ad", mem_ad, 15'h0);
    chk("rst_mid_be", mem_be, 2'b00);
    chk("rst_mid_stall", stall, 1'b0);
    rst = 1'b0;
    model_rdata = 16'h0;
    req_cycles = 0;
    q.delete();
    sb_en = 1'b1;
    do_op(0, 1, 0, 16'h0040, 16'h0000, 1, 0, 0);
    do_op(0, 1, 0, 16'h0030, 16'h0000, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
